// File: rtl/sm_reg_reader.sv
// Store-multiple read sequencer: walks the selected registers in ascending
// index order, fetching each over the register file's asynchronous read port
// and writing it to consecutive memory addresses via a valid/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; xfer_count holds the last transfer's count
// SEL    | point rf_raddr at the lowest pending register
// FETCH  | capture rf_rdata and the current address into the write regs
// WRITE  | mem_we held high until mem_ready; then retire the register
// DONE   | one-cycle done pulse, then back to IDLE
module sm_reg_reader #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NREG-1:0]   mask,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [3:0]        xfer_count,
    output logic [IDX_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_FETCH = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NREG-1:0]     pend_q, pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    raddr_q, raddr_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [NREG-1:0]     clr_bit;
    logic [NREG-1:0]     pend_after;
    logic                accept;

    // Lowest set bit wins, so scanning downward leaves the smallest index.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NREG-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // One-hot of the register currently being written, used to retire it.
    always_comb begin
        clr_bit          = '0;
        clr_bit[raddr_q] = 1'b1;
        pend_after       = pend_q & ~clr_bit;
        accept           = (state_q == S_WRITE) && we_q && mem_ready;
    end

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        we_d    = we_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d = 4'd0;
                    if (mask != '0) begin
                        pend_d  = mask;
                        addr_d  = base_addr;
                        state_d = S_SEL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SEL: begin
                raddr_d = lowest_idx(pend_q);
                state_d = S_FETCH;
            end
            S_FETCH: begin
                wdata_d = rf_rdata;
                maddr_d = addr_q;
                we_d    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (accept) begin
                    pend_d  = pend_after;
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + 4'd1;
                    we_d    = 1'b0;
                    state_d = (pend_after == '0) ? S_DONE : S_SEL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                we_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered, so derive them from the next state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            raddr_q <= '0;
            maddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign xfer_count = cnt_q;
    assign rf_raddr   = raddr_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = we_q;

endmodule

// File: tb/tb_sm_reg_reader.sv
// Scoreboard bench for sm_reg_reader: stimulus pushes expected writes and
// done counts; a negedge monitor pops and compares as the DUT presents them.
module tb_sm_reg_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  mask;
    logic [15:0] base_addr;
    logic        busy;
    logic        done;
    logic [3:0]  xfer_count;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready;

    logic [15:0] regs [8];
    logic [31:0] exp_wr [$];
    logic [3:0]  exp_done [$];

    int n_cmp;
    int n_err;
    int n_wr;

    assign rf_rdata = regs[rf_raddr];

    sm_reg_reader dut (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .mask       (mask),
        .base_addr  (base_addr),
        .busy       (busy),
        .done       (done),
        .xfer_count (xfer_count),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted write and every done pulse is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we && !busy) chk("we_outside_busy", 32'(mem_we), 32'd0);
            if (mem_we && mem_ready) begin
                n_wr++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e[31:16]));
                    chk("wr_data", 32'(mem_wdata), 32'(e[15:0]));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    logic [3:0] c;
                    c = exp_done.pop_front();
                    chk("done_count", 32'(xfer_count), 32'(c));
                end
            end
        end
    end

    // Queue the expected response, then present start for one cycle.
    task automatic start_xfer(input logic [7:0] m, input logic [15:0] b);
        logic [15:0] a;
        logic [3:0]  c;
        a = b;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                exp_wr.push_back({a, regs[i]});
                a = a + 16'd1;
                c = c + 4'd1;
            end
        end
        exp_done.push_back(c);
        @(posedge clk); #1;
        start     = 1'b1;
        mask      = m;
        base_addr = b;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            if (!busy && exp_wr.size() == 0 && exp_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        int w0;
        bit seen;
        n_cmp = 0; n_err = 0; n_wr = 0;
        rst = 1'b1; start = 1'b0; mask = '0; base_addr = '0; mem_ready = 1'b1;
        regs[0] = 16'h1111; regs[1] = 16'hAAAA; regs[2] = 16'h2222; regs[3] = 16'h3333;
        regs[4] = 16'h4444; regs[5] = 16'h5555; regs[6] = 16'h6666; regs[7] = 16'hBEEF;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_raddr", 32'(rf_raddr), 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_count", 32'(xfer_count), 32'd0);
        rst = 1'b0;

        // R0 and R2 to 0x0040/0x0041, ready always high.
        w0 = n_wr;
        start_xfer(8'h05, 16'h0040);
        wait_idle("t1_complete");
        chk("t1_nwrites", 32'(n_wr - w0), 32'd2);
        chk("t1_count_held", 32'(xfer_count), 32'd2);

        // Empty mask: done in the cycle after start is sampled, no writes.
        w0 = n_wr;
        start_xfer(8'h00, 16'h1234);
        @(negedge clk);
        chk("t2_done_next", 32'(done), 32'd1);
        chk("t2_no_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("t2_busy_clear", 32'(busy), 32'd0);
        chk("t2_done_clear", 32'(done), 32'd0);
        wait_idle("t2_complete");
        chk("t2_nwrites", 32'(n_wr - w0), 32'd0);

        // R7 with a three-cycle stall: outputs held until the handshake.
        w0 = n_wr;
        mem_ready = 1'b0;
        start_xfer(8'h80, 16'h0100);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we) begin seen = 1'b1; break; end
        end
        chk("t3_we_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (k == 3) mem_ready = 1'b1;
                @(negedge clk);
            end
            chk("t3_we_held",    32'(mem_we), 32'd1);
            chk("t3_addr_held",  32'(mem_addr), 32'h0100);
            chk("t3_wdata_held", 32'(mem_wdata), 32'hBEEF);
        end
        wait_idle("t3_complete");
        chk("t3_nwrites", 32'(n_wr - w0), 32'd1);

        // Address wrap from 0xFFFF to 0x0000.
        w0 = n_wr;
        start_xfer(8'h03, 16'hFFFF);
        wait_idle("t4_complete");
        chk("t4_nwrites", 32'(n_wr - w0), 32'd2);
        chk("t4_count", 32'(xfer_count), 32'd2);

        // Full mask, reset while R3 sits in WRITE.
        w0 = n_wr;
        mem_ready = 1'b1;
        start_xfer(8'hFF, 16'h0200);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (n_wr - w0 >= 3) begin seen = 1'b1; break; end
        end
        #1 mem_ready = 1'b0;
        chk("t5_three_written", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we && rf_raddr == 3'd3) begin seen = 1'b1; break; end
        end
        chk("t5_r3_write", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_we",    32'(mem_we), 32'd0);
        chk("t5_async_busy",  32'(busy), 32'd0);
        chk("t5_async_addr",  32'(mem_addr), 32'd0);
        chk("t5_async_wdata", 32'(mem_wdata), 32'd0);
        chk("t5_async_raddr", 32'(rf_raddr), 32'd0);
        chk("t5_async_count", 32'(xfer_count), 32'd0);
        exp_wr.delete();
        exp_done.delete();
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_idle_we", 32'(mem_we), 32'd0);
            chk("t5_idle_busy", 32'(busy), 32'd0);
        end
        chk("t5_nwrites", 32'(n_wr - w0), 32'd3);

        // Start pulse during a transfer is ignored.
        w0 = n_wr;
        start_xfer(8'h0A, 16'h0300);
        @(posedge clk); #1;
        start = 1'b1; mask = 8'hFF; base_addr = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("t6_complete");
        chk("t6_nwrites", 32'(n_wr - w0), 32'd2);
        chk("t6_count", 32'(xfer_count), 32'd2);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
